// File: rtl/core_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | core_pkg                                                                   |
// | Opcode constants, field width defaults and interlock state encoding.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package core_pkg;

    localparam int REG_W_DEF = 4;
    localparam int OP_W_DEF  = 4;

    localparam logic [3:0] c_OP_LW  = 4'b1000;
    localparam logic [3:0] c_OP_SW  = 4'b1001;
    localparam logic [3:0] c_OP_B   = 4'b1100;
    localparam logic [3:0] c_OP_BR  = 4'b1101;
    localparam logic [3:0] c_OP_PCS = 4'b1110;
    localparam logic [3:0] c_OP_HLT = 4'b1111;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_BR_LD2   = 2'd2;
    localparam logic [1:0] ST_HALTED   = 2'd3;

    // Opcodes that produce no register result and so can never feed a BR operand.
    function automatic logic writes_reg(input logic [3:0] op);
        return !((op == c_OP_SW) || (op == c_OP_B) || (op == c_OP_BR) || (op == c_OP_HLT));
    endfunction

endpackage
`default_nettype wire

// File: rtl/haz_perf_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | haz_perf_cnt                                                               |
// | Saturating event counter, async active-low reset.                          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module haz_perf_cnt #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hazard_ctrl                                                                |
// | Pipeline stall/flush interlock; HAZ_PERF_CNT_EN adds saturating counters.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int REG_W = REG_W_DEF,
    parameter int OP_W  = OP_W_DEF,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OP_W-1:0]  if_id_op,
    input  logic [REG_W-1:0] if_id_rs,
    input  logic [REG_W-1:0] if_id_rt,
    input  logic             if_id_rs_vld,
    input  logic             if_id_rt_vld,
    input  logic [OP_W-1:0]  id_ex_op,
    input  logic [REG_W-1:0] id_ex_rd,
    input  logic             id_ex_setflag,
    input  logic [OP_W-1:0]  ex_mem_op,
    input  logic [REG_W-1:0] ex_mem_rd,
    input  logic [OP_W-1:0]  mem_wb_op,
    input  logic             br_taken,
    input  logic             dmem_busy,
    output logic             pc_hold,
    output logic             if_id_hold,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             back_hold,
    output logic             halt
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] memwait_cnt
`endif
);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;

    logic w_eff_run, w_memwait_cond, w_memwait, w_br_ld2, w_halted;
    logic w_load_use, w_br_op, w_b_flag, w_stall_term, w_br_ld2_entry;

    // A MEM_WAIT cycle with memory done behaves exactly like RUN.
    assign w_halted  = (r_state == ST_HALTED);
    assign w_eff_run = (r_state == ST_RUN) || ((r_state == ST_MEM_WAIT) && !dmem_busy);

    assign w_memwait_cond = dmem_busy && ((ex_mem_op == c_OP_LW) || (ex_mem_op == c_OP_SW));
    assign w_memwait = ((r_state == ST_MEM_WAIT) && dmem_busy)
                     || ((w_eff_run || (r_state == ST_BR_LD2)) && w_memwait_cond);
    assign w_br_ld2  = (r_state == ST_BR_LD2) && !w_memwait_cond;

    assign w_load_use = (id_ex_op == c_OP_LW) && (id_ex_rd != '0)
                      && ((if_id_rs_vld && (if_id_rs == id_ex_rd))
                       || (if_id_rt_vld && (if_id_rt == id_ex_rd)));

    assign w_br_op = (if_id_op == c_OP_BR)
                   && (((if_id_rs == id_ex_rd) && (id_ex_rd != '0) && writes_reg(id_ex_op))
                    || ((if_id_rs == ex_mem_rd) && (ex_mem_rd != '0) && (ex_mem_op == c_OP_LW)));

    assign w_b_flag = (if_id_op == c_OP_B) && id_ex_setflag;

    assign w_stall_term = w_eff_run && !w_memwait_cond && (w_load_use || w_br_op || w_b_flag);

    // A load feeding a branch needs a second bubble beyond the one the BR term gives.
    assign w_br_ld2_entry = (if_id_op == c_OP_BR) && (id_ex_op == c_OP_LW)
                          && (id_ex_rd != '0) && (if_id_rs == id_ex_rd);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_HALTED: w_state_nxt = ST_HALTED;
            ST_BR_LD2: w_state_nxt = w_memwait_cond ? ST_MEM_WAIT : ST_RUN;
            default: begin
                if (w_memwait_cond || ((r_state == ST_MEM_WAIT) && dmem_busy)) begin
                    w_state_nxt = ST_MEM_WAIT;
                end else if (mem_wb_op == c_OP_HLT) begin
                    w_state_nxt = ST_HALTED;
                end else if (w_br_ld2_entry) begin
                    w_state_nxt = ST_BR_LD2;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign pc_hold      = rst_n && (w_halted || w_memwait || w_br_ld2 || w_stall_term);
    assign if_id_hold   = rst_n && (w_halted || w_memwait || w_br_ld2 || w_stall_term);
    assign id_ex_bubble = rst_n && (w_br_ld2 || w_stall_term);
    assign back_hold    = rst_n && (w_halted || w_memwait);
    assign halt         = rst_n && w_halted;
    assign if_id_flush  = rst_n && w_eff_run && !w_memwait_cond
                        && !(w_load_use || w_br_op || w_b_flag) && br_taken;

`ifdef HAZ_PERF_CNT_EN
    haz_perf_cnt #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (id_ex_bubble && !w_halted),
        .cnt   (stall_cnt)
    );

    haz_perf_cnt #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (if_id_flush && !w_halted),
        .cnt   (flush_cnt)
    );

    haz_perf_cnt #(.WIDTH(CNT_W)) u_memwait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_memwait && !w_halted),
        .cnt   (memwait_cnt)
    );
`else
    logic w_unused_cnt_w;
    assign w_unused_cnt_w = |CNT_W;
`endif

endmodule
`default_nettype wire
